// File: rtl/ula_operand_sequencer.sv
// ula_operand_sequencer: loads ULA operands A, B, F on successive button presses and captures the ULA result and overflow flag
module ula_operand_sequencer #(
  parameter int BITS  = 8,
  parameter int VETOR = 2,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BITS-1:0]  sw_data,
  input  logic [VETOR-1:0] sw_func,
  input  logic             btn_next,
  input  logic [BITS-1:0]  alu_result,
  input  logic             alu_flag,
  output logic [BITS-1:0]  op_a,
  output logic [BITS-1:0]  op_b,
  output logic [VETOR-1:0] op_f,
  output logic [2:0]       state_o,
  output logic [BITS-1:0]  result_q,
  output logic             flag_q,
  output logic             result_valid,
  output logic [CNT_W-1:0] ovf_count
);
  typedef enum logic [2:0] {
    WAIT_A = 3'd0,
    WAIT_B = 3'd1,
    WAIT_F = 3'd2,
    EXEC   = 3'd3,
    SHOW   = 3'd4
  } state_t;
  state_t           state_q, state_d;
  logic             btn_q, press;
  logic [BITS-1:0]  op_a_q, op_a_d, op_b_q, op_b_d, result_d;
  logic [VETOR-1:0] op_f_q, op_f_d;
  logic             flag_d, valid_q, valid_d;
  logic [CNT_W-1:0] ovf_q, ovf_d;
  assign press        = btn_next & ~btn_q;
  assign op_a         = op_a_q;
  assign op_b         = op_b_q;
  assign op_f         = op_f_q;
  assign state_o      = state_q;
  assign result_valid = valid_q;
  assign ovf_count    = ovf_q;
  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    op_f_d   = op_f_q;
    result_d = result_q;
    flag_d   = flag_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    case (state_q)
      WAIT_A: begin
        op_a_d  = press ? sw_data : op_a_q;
        state_d = press ? WAIT_B : WAIT_A;
      end
      WAIT_B: begin
        op_b_d  = press ? sw_data : op_b_q;
        state_d = press ? WAIT_F : WAIT_B;
      end
      WAIT_F: begin
        op_f_d  = press ? sw_func : op_f_q;
        state_d = press ? EXEC : WAIT_F;
      end
      EXEC: begin
        result_d = alu_result;
        flag_d   = alu_flag;
        valid_d  = 1'b1;
        ovf_d    = (alu_flag && ovf_q != '1) ? ovf_q + CNT_W'(1) : ovf_q;
        state_d  = SHOW;
      end
      SHOW: begin
        valid_d = press ? 1'b0 : valid_q;
        state_d = press ? WAIT_A : SHOW;
      end
      default: state_d = WAIT_A;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= WAIT_A;
      btn_q    <= 1'b1;
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_f_q   <= '0;
      result_q <= '0;
      flag_q   <= 1'b0;
      valid_q  <= 1'b0;
      ovf_q    <= '0;
    end else begin
      state_q  <= state_d;
      btn_q    <= btn_next;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      op_f_q   <= op_f_d;
      result_q <= result_d;
      flag_q   <= flag_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end
endmodule

// File: tb/tb_ula_operand_sequencer.sv
// tb_ula_operand_sequencer: scoreboard bench driving directed operand loads through a behavioural ULA
module tb_ula_operand_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] sw_data = '0;
  logic [1:0] sw_func = '0;
  logic       btn_next = 1'b1;
  logic [7:0] op_a, op_b, alu_result, result_q;
  logic [1:0] op_f;
  logic [2:0] state_o;
  logic       alu_flag, flag_q, result_valid;
  logic [3:0] ovf_count;
  logic [7:0] op_a2, op_b2, alu_result2, result_q2;
  logic [1:0] op_f2;
  logic [2:0] state_o2;
  logic       alu_flag2, flag_q2, result_valid2;
  logic [1:0] ovf_count2;
  int checks = 0, failures = 0, seen = 0;
  typedef struct packed {
    logic [7:0] res;
    logic       flag;
    logic [3:0] cnt;
  } exp_t;
  exp_t exp_q[$];
  always #5 clk = ~clk;
  function automatic logic [8:0] ula(input logic [7:0] a, input logic [7:0] b, input logic [1:0] f);
    logic [7:0] s, d;
    s = a + b;
    d = a - b;
    case (f)
      2'b00:   ula = {1'b0, a & b};
      2'b01:   ula = {1'b0, a | b};
      2'b10:   ula = {(a[7] == b[7]) && (s[7] != a[7]), s};
      default: ula = {(a[7] != b[7]) && (d[7] != a[7]), d};
    endcase
  endfunction
  assign {alu_flag, alu_result}   = ula(op_a, op_b, op_f);
  assign {alu_flag2, alu_result2} = ula(op_a2, op_b2, op_f2);
  ula_operand_sequencer dut (
    .clk(clk), .reset(reset), .sw_data(sw_data), .sw_func(sw_func), .btn_next(btn_next),
    .alu_result(alu_result), .alu_flag(alu_flag), .op_a(op_a), .op_b(op_b), .op_f(op_f),
    .state_o(state_o), .result_q(result_q), .flag_q(flag_q), .result_valid(result_valid),
    .ovf_count(ovf_count)
  );
  ula_operand_sequencer #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .sw_data(sw_data), .sw_func(sw_func), .btn_next(btn_next),
    .alu_result(alu_result2), .alu_flag(alu_flag2), .op_a(op_a2), .op_b(op_b2), .op_f(op_f2),
    .state_o(state_o2), .result_q(result_q2), .flag_q(flag_q2), .result_valid(result_valid2),
    .ovf_count(ovf_count2)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic press(input logic [7:0] d, input logic [1:0] f);
    sw_data = d;
    sw_func = f;
    btn_next = 1'b1;
    @(posedge clk);
    #1 btn_next = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] f,
                        input logic [7:0] res, input logic flag, input logic [3:0] cnt);
    press(a, 2'b00);
    press(b, 2'b00);
    exp_q.push_back('{res: res, flag: flag, cnt: cnt});
    press(8'h00, f);
    chk("state_show", state_o, 3'd4);
    press(8'h00, 2'b00);
    chk("state_back_wait_a", state_o, 3'd0);
    chk("valid_cleared", result_valid, 1'b0);
  endtask
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (result_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        seen++;
        chk("result_q", result_q, e.res);
        chk("flag_q", flag_q, e.flag);
        chk("ovf_count", ovf_count, e.cnt);
      end
    end
    prev_valid <= result_valid;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", state_o, 3'd0);
    chk("rst_op_a", op_a, 8'h00);
    chk("rst_op_b", op_b, 8'h00);
    chk("rst_op_f", op_f, 2'b00);
    chk("rst_result", result_q, 8'h00);
    chk("rst_flag", flag_q, 1'b0);
    chk("rst_valid", result_valid, 1'b0);
    chk("rst_ovf", ovf_count, 4'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("btn_through_reset_no_advance", state_o, 3'd0);
    btn_next = 1'b0;
    @(posedge clk);
    #1;
    run_op(8'h7F, 8'h01, 2'b10, 8'h80, 1'b1, 4'd1);
    run_op(8'h80, 8'hFF, 2'b10, 8'h7F, 1'b1, 4'd2);
    run_op(8'h7F, 8'h01, 2'b11, 8'h7E, 1'b0, 4'd2);
    run_op(8'hF0, 8'h3C, 2'b00, 8'h30, 1'b0, 4'd2);
    run_op(8'hF0, 8'h3C, 2'b01, 8'hFC, 1'b0, 4'd2);
    run_op(8'h7F, 8'h01, 2'b10, 8'h80, 1'b1, 4'd3);
    run_op(8'h7F, 8'h01, 2'b10, 8'h80, 1'b1, 4'd4);
    run_op(8'h80, 8'hFF, 2'b10, 8'h7F, 1'b1, 4'd5);
    chk("sat_ovf_cntw2", ovf_count2, 2'd3);
    chk("op_a_holds", op_a, 8'h80);
    btn_next = 1'b1;
    repeat (10) @(posedge clk);
    #1 btn_next = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("held_btn_one_advance", state_o, 3'd1);
    press(8'h55, 2'b00);
    chk("state_wait_f", state_o, 3'd2);
    chk("op_b_loaded", op_b, 8'h55);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_state", state_o, 3'd0);
    chk("midrst_op_a", op_a, 8'h00);
    chk("midrst_op_b", op_b, 8'h00);
    chk("midrst_result", result_q, 8'h00);
    chk("midrst_flag", flag_q, 1'b0);
    chk("midrst_valid", result_valid, 1'b0);
    chk("midrst_ovf", ovf_count, 4'd0);
    chk("midrst_ovf_sat", ovf_count2, 2'd0);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("results_seen", seen, 8);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
